ceespu_memory: RTL and testbench

//  Memory-access pipeline stage directly downstream of the execute stage. Consumes the

---
 rtl/ceespu_memory_pkg.sv | 40 ++++
 rtl/ceespu_load_align.sv | 52 +++++
 rtl/ceespu_memory.sv | 199 +++++++++++++++++++
 tb/tb_ceespu_memory.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ceespu_memory_pkg.sv
// ---------------------------------------------------------------------------
// ceespu_memory_pkg
// Shared definitions for the memory-access stage:
//   - access size codes carried in selMem[1:0]
//   - memory-stage FSM state encoding
//   - writeback source select codes (forwarded, never decoded here)
//   - sign/zero extension helper used by the load aligner
// ---------------------------------------------------------------------------
package ceespu_memory_pkg;

  // Access size codes, selMem[1:0]
  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  // Writeback source codes (interpreted by the writeback stage only)
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  // Memory-stage FSM states
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } mem_state_t;

  // Extend a 16-bit lane to 32 bits; is_byte selects an 8-bit source in [7:0].
  function automatic logic [31:0] extend_lane(input logic [15:0] val,
                                              input logic        is_byte,
                                              input logic        zext);
    logic [31:0] res;
    if (is_byte) begin
      res = zext ? {24'h00_0000, val[7:0]} : {{24{val[7]}}, val[7:0]};
    end else begin
      res = zext ? {16'h0000, val} : {{16{val[15]}}, val};
    end
    return res;
  endfunction

endpackage

// File: rtl/ceespu_load_align.sv
// ---------------------------------------------------------------------------
// ceespu_load_align
// Combinational load data aligner: selects the addressed byte / half-word
// lane from the bus read word and extends it to 32 bits.
// Ports:
//   i_rdata  [31:0]  read data word from the bus
//   i_addr   [1:0]   low byte-address bits of the access
//   i_selMem [2:0]   [1:0] size (word/half/byte), [2] 1=zero-extend
//   o_data   [31:0]  aligned, extended load data
// Half-word accesses look at i_addr[1] only; word accesses ignore i_addr.
// ---------------------------------------------------------------------------
module ceespu_load_align
  import ceespu_memory_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr,
  input  logic [2:0]  i_selMem,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection for byte and half-word accesses
  always_comb begin
    w_byte = 8'h00;
    case (i_addr)
      2'd0:    w_byte = i_rdata[7:0];
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = 8'h00;
    endcase
    if (i_addr[1]) begin
      w_half = i_rdata[31:16];
    end else begin
      w_half = i_rdata[15:0];
    end
  end

  // Size decode and extension; an unused size code behaves as a word
  always_comb begin
    o_data = i_rdata;
    case (i_selMem[1:0])
      SZ_BYTE: o_data = extend_lane({8'h00, w_byte}, 1'b1, i_selMem[2]);
      SZ_HALF: o_data = extend_lane(w_half, 1'b0, i_selMem[2]);
      SZ_WORD: o_data = i_rdata;
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/ceespu_memory.sv
// ---------------------------------------------------------------------------
// ceespu_memory
// Memory-access pipeline stage. Non-memory instructions pass to the
// writeback registers in one cycle. Memory instructions are captured, a
// bus transaction is held until ack (or watchdog abort), and the aligned
// load data plus the captured fields are then registered for writeback.
// Ports:
//   I_clk, I_rst (async, active-low)
//   I_we, I_aluResult, I_memAddress, I_storeData, I_memE, I_memWe,
//   I_selMem, I_selWb, I_regD, I_PC         execute pipeline register
//   O_dmem_req/addr/we/wdata, I_dmem_ack/rdata  data bus
//   O_busy       combinational stall request upstream
//   O_bus_error  one-cycle pulse on watchdog abort
//   O_we, O_regD, O_selWb, O_PC, O_aluResult, O_memData  to writeback
// ---------------------------------------------------------------------------
module ceespu_memory
  import ceespu_memory_pkg::*;
#(
  parameter int P_TIMEOUT = 64,
  parameter int P_CNT_W   = 7
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_we,
  input  logic [31:0] I_aluResult,
  input  logic [24:0] I_memAddress,
  input  logic [31:0] I_storeData,
  input  logic        I_memE,
  input  logic [3:0]  I_memWe,
  input  logic [2:0]  I_selMem,
  input  logic [1:0]  I_selWb,
  input  logic [4:0]  I_regD,
  input  logic [24:0] I_PC,
  output logic        O_dmem_req,
  output logic [22:0] O_dmem_addr,
  output logic [3:0]  O_dmem_we,
  output logic [31:0] O_dmem_wdata,
  input  logic        I_dmem_ack,
  input  logic [31:0] I_dmem_rdata,
  output logic        O_busy,
  output logic        O_bus_error,
  output logic        O_we,
  output logic [4:0]  O_regD,
  output logic [1:0]  O_selWb,
  output logic [24:0] O_PC,
  output logic [31:0] O_aluResult,
  output logic [31:0] O_memData
);

  mem_state_t         r_state;
  mem_state_t         w_next_state;
  logic [P_CNT_W-1:0] r_cnt;
  logic               r_req;
  logic [24:0]        r_addr;
  logic [3:0]         r_dmem_we;
  logic [31:0]        r_wdata;
  logic [2:0]         r_selMem;
  logic [4:0]         r_regD;
  logic [1:0]         r_selWb;
  logic [24:0]        r_PC;
  logic [31:0]        r_aluResult;
  logic               r_we;
  logic               w_timeout;
  logic [31:0]        w_load_data;

  // Last watchdog cycle: abort unless ack arrives in this same cycle
  assign w_timeout = (r_state == ST_BUS) && (r_cnt == P_CNT_W'(P_TIMEOUT - 1));

  assign O_dmem_req   = r_req;
  assign O_dmem_addr  = r_addr[24:2];
  assign O_dmem_we    = r_dmem_we;
  assign O_dmem_wdata = r_wdata;

  ceespu_load_align u_align (
    .i_rdata  (I_dmem_rdata),
    .i_addr   (r_addr[1:0]),
    .i_selMem (r_selMem),
    .o_data   (w_load_data)
  );

  // FSM state register
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (I_memE) begin
          w_next_state = ST_BUS;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_BUS: begin
        if (I_dmem_ack || w_timeout) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_BUS;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // FSM output logic: stall while a memory op is being captured or waiting
  always_comb begin
    O_busy = 1'b0;
    case (r_state)
      ST_IDLE: O_busy = I_memE;
      ST_BUS:  O_busy = !I_dmem_ack && !w_timeout;
      default: O_busy = 1'b0;
    endcase
  end

  // Bus capture, watchdog and writeback pipeline registers
  always_ff @(posedge I_clk or negedge I_rst) begin
    if (!I_rst) begin
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_addr      <= 25'h000_0000;
      r_dmem_we   <= 4'h0;
      r_wdata     <= 32'h0000_0000;
      r_selMem    <= 3'd0;
      r_regD      <= 5'd0;
      r_selWb     <= 2'd0;
      r_PC        <= 25'h000_0000;
      r_aluResult <= 32'h0000_0000;
      r_we        <= 1'b0;
      O_bus_error <= 1'b0;
      O_we        <= 1'b0;
      O_regD      <= 5'd0;
      O_selWb     <= 2'd0;
      O_PC        <= 25'h000_0000;
      O_aluResult <= 32'h0000_0000;
      O_memData   <= 32'h0000_0000;
    end else begin
      O_bus_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (I_memE) begin
            r_addr      <= I_memAddress;
            r_dmem_we   <= I_memWe;
            r_wdata     <= I_storeData;
            r_selMem    <= I_selMem;
            r_regD      <= I_regD;
            r_selWb     <= I_selWb;
            r_PC        <= I_PC;
            r_aluResult <= I_aluResult;
            r_we        <= I_we;
            r_req       <= 1'b1;
            r_cnt       <= '0;
            O_we        <= 1'b0;
          end else begin
            O_we        <= I_we;
            O_regD      <= I_regD;
            O_selWb     <= I_selWb;
            O_PC        <= I_PC;
            O_aluResult <= I_aluResult;
            O_memData   <= 32'h0000_0000;
          end
        end
        ST_BUS: begin
          if (I_dmem_ack) begin
            O_we        <= r_we;
            O_regD      <= r_regD;
            O_selWb     <= r_selWb;
            O_PC        <= r_PC;
            O_aluResult <= r_aluResult;
            // Stores have nonzero byte enables and return no data
            O_memData   <= (r_dmem_we != 4'h0) ? 32'h0000_0000 : w_load_data;
            r_req       <= 1'b0;
            r_dmem_we   <= 4'h0;
            r_cnt       <= '0;
          end else if (w_timeout) begin
            O_bus_error <= 1'b1;
            O_we        <= 1'b0;
            r_req       <= 1'b0;
            r_dmem_we   <= 4'h0;
            r_cnt       <= '0;
          end else begin
            r_cnt       <= r_cnt + P_CNT_W'(1);
          end
        end
        default: begin
          r_req <= 1'b0;
          O_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ceespu_memory.sv
// ---------------------------------------------------------------------------
// tb_ceespu_memory
// Directed bench for the memory stage with a scoreboard of expected
// writeback results. Runs with a short watchdog (P_TIMEOUT = 8).
// ---------------------------------------------------------------------------
module tb_ceespu_memory;

  localparam int P_TIMEOUT = 8;
  localparam int P_CNT_W   = 4;

  logic        I_clk;
  logic        I_rst;
  logic        I_we;
  logic [31:0] I_aluResult;
  logic [24:0] I_memAddress;
  logic [31:0] I_storeData;
  logic        I_memE;
  logic [3:0]  I_memWe;
  logic [2:0]  I_selMem;
  logic [1:0]  I_selWb;
  logic [4:0]  I_regD;
  logic [24:0] I_PC;
  logic        O_dmem_req;
  logic [22:0] O_dmem_addr;
  logic [3:0]  O_dmem_we;
  logic [31:0] O_dmem_wdata;
  logic        I_dmem_ack;
  logic [31:0] I_dmem_rdata;
  logic        O_busy;
  logic        O_bus_error;
  logic        O_we;
  logic [4:0]  O_regD;
  logic [1:0]  O_selWb;
  logic [24:0] O_PC;
  logic [31:0] O_aluResult;
  logic [31:0] O_memData;

  typedef struct {
    logic        we;
    logic [4:0]  regD;
    logic [1:0]  selWb;
    logic [24:0] pc;
    logic [31:0] alu;
    logic [31:0] mem;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  ceespu_memory #(.P_TIMEOUT(P_TIMEOUT), .P_CNT_W(P_CNT_W)) dut (
    .I_clk(I_clk), .I_rst(I_rst), .I_we(I_we), .I_aluResult(I_aluResult),
    .I_memAddress(I_memAddress), .I_storeData(I_storeData), .I_memE(I_memE),
    .I_memWe(I_memWe), .I_selMem(I_selMem), .I_selWb(I_selWb), .I_regD(I_regD),
    .I_PC(I_PC), .O_dmem_req(O_dmem_req), .O_dmem_addr(O_dmem_addr),
    .O_dmem_we(O_dmem_we), .O_dmem_wdata(O_dmem_wdata), .I_dmem_ack(I_dmem_ack),
    .I_dmem_rdata(I_dmem_rdata), .O_busy(O_busy), .O_bus_error(O_bus_error),
    .O_we(O_we), .O_regD(O_regD), .O_selWb(O_selWb), .O_PC(O_PC),
    .O_aluResult(O_aluResult), .O_memData(O_memData)
  );

  initial I_clk = 1'b0;
  always #5 I_clk = ~I_clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge I_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_we"},    32'(O_we),        32'(e.we));
      chk({tag, "_regD"},  32'(O_regD),      32'(e.regD));
      chk({tag, "_selWb"}, 32'(O_selWb),     32'(e.selWb));
      chk({tag, "_pc"},    32'(O_PC),        32'(e.pc));
      chk({tag, "_alu"},   O_aluResult,      e.alu);
      chk({tag, "_mem"},   O_memData,        e.mem);
    end
  endtask

  task automatic alu_op(input string tag, input logic [31:0] alu, input logic we,
                        input logic [4:0] rd, input logic [24:0] pc);
    I_memE = 1'b0; I_memWe = 4'h0; I_we = we; I_aluResult = alu;
    I_regD = rd; I_PC = pc; I_selWb = 2'd0;
    sb.push_back('{we, rd, 2'd0, pc, alu, 32'h0000_0000});
    #1;
    chk({tag, "_busy"}, 32'(O_busy), 32'd0);
    tick();
    chk({tag, "_busy_after"}, 32'(O_busy), 32'd0);
    wb_check(tag);
  endtask

  // One memory op; ack arrives after 'waits' BUS cycles without ack.
  task automatic mem_op(input string tag, input logic [24:0] addr, input logic [3:0] we4,
                        input logic [31:0] wdata, input logic [2:0] sel, input logic we,
                        input logic [4:0] rd, input logic [24:0] pc, input logic [31:0] alu,
                        input int waits, input logic [31:0] rdata, input logic [31:0] expmem);
    int busy_cycles;
    busy_cycles = 0;
    I_memE = 1'b1; I_memAddress = addr; I_memWe = we4; I_storeData = wdata;
    I_selMem = sel; I_we = we; I_regD = rd; I_PC = pc; I_aluResult = alu;
    I_selWb = 2'd1;
    sb.push_back('{we, rd, 2'd1, pc, alu, expmem});
    #1;
    if (O_busy) busy_cycles++;
    tick();
    chk({tag, "_req"},   32'(O_dmem_req),  32'd1);
    chk({tag, "_addr"},  32'(O_dmem_addr), 32'(addr[24:2]));
    chk({tag, "_dwe"},   32'(O_dmem_we),   32'(we4));
    chk({tag, "_wdata"}, O_dmem_wdata,     wdata);
    chk({tag, "_bubble"}, 32'(O_we),       32'd0);
    // Scramble upstream fields: the bus must keep the captured values
    I_memAddress = ~addr; I_storeData = ~wdata; I_memWe = ~we4; I_regD = ~rd;
    for (int w = 0; w < waits; w++) begin
      #1;
      if (O_busy) busy_cycles++;
      chk({tag, "_hold_addr"}, 32'(O_dmem_addr), 32'(addr[24:2]));
      chk({tag, "_hold_req"},  32'(O_dmem_req),  32'd1);
      chk({tag, "_hold_we"},   32'(O_we),        32'd0);
      tick();
    end
    I_dmem_ack = 1'b1; I_dmem_rdata = rdata;
    #1;
    if (O_busy) busy_cycles++;
    chk({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(waits + 1));
    chk({tag, "_ack_wdata"}, O_dmem_wdata, wdata);
    tick();
    I_dmem_ack = 1'b0; I_dmem_rdata = 32'h0; I_memE = 1'b0; I_memWe = 4'h0;
    wb_check(tag);
    chk({tag, "_req_drop"}, 32'(O_dmem_req), 32'd0);
    chk({tag, "_no_err"},   32'(O_bus_error), 32'd0);
  endtask

  initial begin
    I_rst = 1'b0; I_we = 1'b0; I_aluResult = 32'h0; I_memAddress = 25'h0;
    I_storeData = 32'h0; I_memE = 1'b0; I_memWe = 4'h0; I_selMem = 3'd0;
    I_selWb = 2'd0; I_regD = 5'd0; I_PC = 25'h0; I_dmem_ack = 1'b0;
    I_dmem_rdata = 32'h0;
    tick();
    tick();
    chk("rst_req",  32'(O_dmem_req),  32'd0);
    chk("rst_dwe",  32'(O_dmem_we),   32'd0);
    chk("rst_we",   32'(O_we),        32'd0);
    chk("rst_err",  32'(O_bus_error), 32'd0);
    chk("rst_busy", 32'(O_busy),      32'd0);
    chk("rst_alu",  O_aluResult,      32'd0);
    chk("rst_mem",  O_memData,        32'd0);
    I_rst = 1'b1;
    tick();

    // 1. ALU pass-through
    alu_op("alu1", 32'h1234_5678, 1'b1, 5'd5, 25'h000_0100);
    alu_op("alu2", 32'hA5A5_0F0F, 1'b0, 5'd17, 25'h000_0104);

    // 2. Signed byte load, ack in first BUS cycle
    mem_op("lb_s", 25'h000_0003, 4'h0, 32'h0, 3'b010, 1'b1, 5'd7, 25'h000_0108,
           32'h0000_0003, 0, 32'h80FF_0011, 32'hFFFF_FF80);
    // 3. Unsigned half load, 3 wait cycles
    mem_op("lh_u", 25'h000_0006, 4'h0, 32'h0, 3'b101, 1'b1, 5'd8, 25'h000_010C,
           32'h0000_0006, 3, 32'hBEEF_CAFE, 32'h0000_BEEF);
    // Extra lanes: signed half low lane, unsigned byte lane 1, word
    mem_op("lh_s", 25'h000_0004, 4'h0, 32'h0, 3'b001, 1'b1, 5'd9, 25'h000_0110,
           32'h0000_0004, 1, 32'h1234_8001, 32'hFFFF_8001);
    mem_op("lb_u", 25'h000_0021, 4'h0, 32'h0, 3'b110, 1'b1, 5'd10, 25'h000_0114,
           32'h0000_0021, 0, 32'h0000_9A00, 32'h0000_009A);
    mem_op("lw",   25'h000_0043, 4'h0, 32'h0, 3'b000, 1'b1, 5'd11, 25'h000_0118,
           32'h0000_0043, 2, 32'hCAFE_F00D, 32'hCAFE_F00D);
    // 4. Word store
    mem_op("sw", 25'h000_0010, 4'b1111, 32'hDEAD_BEEF, 3'b000, 1'b0, 5'd0, 25'h000_011C,
           32'h0000_0010, 2, 32'h5555_5555, 32'h0000_0000);
    alu_op("alu3", 32'h0BAD_F00D, 1'b1, 5'd3, 25'h000_0120);

    // 5a. Load with no ack: watchdog abort
    I_memE = 1'b1; I_memAddress = 25'h000_0008; I_memWe = 4'h0; I_selMem = 3'b000;
    I_we = 1'b1; I_regD = 5'd12; I_PC = 25'h000_0124;
    #1;
    chk("to_busy_cap", 32'(O_busy), 32'd1);
    tick();
    for (int c = 1; c < P_TIMEOUT; c++) begin
      #1;
      chk("to_busy_wait", 32'(O_busy), 32'd1);
      chk("to_err_early", 32'(O_bus_error), 32'd0);
      tick();
    end
    #1;
    chk("to_busy_last", 32'(O_busy), 32'd0);
    chk("to_req_last",  32'(O_dmem_req), 32'd1);
    tick();
    chk("to_err_pulse", 32'(O_bus_error), 32'd1);
    chk("to_we",        32'(O_we), 32'd0);
    chk("to_req_drop",  32'(O_dmem_req), 32'd0);
    alu_op("to_alu", 32'h0000_0042, 1'b1, 5'd13, 25'h000_0128);
    chk("to_err_once", 32'(O_bus_error), 32'd0);

    // 5b. Ack on the last watchdog cycle wins
    mem_op("to_ack", 25'h000_000C, 4'h0, 32'h0, 3'b000, 1'b1, 5'd14, 25'h000_012C,
           32'h0000_000C, P_TIMEOUT - 1, 32'h7777_1111, 32'h7777_1111);

    // 6. Async reset mid-BUS, then a stray ack
    I_memE = 1'b1; I_memAddress = 25'h000_0030; I_memWe = 4'h0; I_selMem = 3'b000;
    I_we = 1'b1; I_regD = 5'd15; I_PC = 25'h000_0130;
    tick();
    chk("ar_req_before", 32'(O_dmem_req), 32'd1);
    I_memE = 1'b0; I_we = 1'b0;
    #2;
    I_rst = 1'b0;
    #1;
    chk("ar_req_now", 32'(O_dmem_req), 32'd0);
    chk("ar_busy",    32'(O_busy), 32'd0);
    #1;
    I_rst = 1'b1;
    I_dmem_ack = 1'b1; I_dmem_rdata = 32'h1111_2222;
    tick();
    chk("ar_stray_we",  32'(O_we), 32'd0);
    chk("ar_stray_req", 32'(O_dmem_req), 32'd0);
    I_dmem_ack = 1'b0;
    tick();
    chk("ar_stray_we2", 32'(O_we), 32'd0);
    alu_op("ar_alu", 32'hFEED_0001, 1'b1, 5'd16, 25'h000_0134);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
